// File: rtl/bus_mem_pipeline_bridge.sv
// Bus-to-memory command bridge: FIFO-decoupled command path, credit-bounded read returns (optional stats: BUS_MEM_BRIDGE_STATS_EN).
// Latency: bus accept at N -> memory request at N+1; read data returned 1 cycle after the memory strobe.
// Backpressure: o_bus_wait_request on command FIFO full or read-beat credit shortfall; read returns are never stalled.

module bus_mem_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign head_dat = mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_dat;
   end
endmodule

module bus_mem_pipeline_bridge #(
   parameter int ADDR_WIDTH        = 32,
   parameter int DATA_WIDTH        = 64,
   parameter int BE_WIDTH          = DATA_WIDTH / 8,
   parameter int BURST_WIDTH       = 8,
   parameter int CMD_DEPTH_LOG2    = 2,
   parameter int MAX_PENDING_BEATS = 16
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [ADDR_WIDTH-1:0]  i_bus_address,
   input  logic [BE_WIDTH-1:0]    i_bus_be,
   input  logic                   i_bus_read_req,
   input  logic                   i_bus_write_req,
   input  logic [DATA_WIDTH-1:0]  i_bus_write_data,
   input  logic [BURST_WIDTH-1:0] i_bus_burst_count,
   input  logic                   i_bus_burst_begin,
   output logic                   o_bus_wait_request,
   output logic [DATA_WIDTH-1:0]  o_bus_read_data,
   output logic                   o_bus_read_data_valid,
   output logic [ADDR_WIDTH-1:0]  o_mem_address,
   output logic [BE_WIDTH-1:0]    o_mem_be,
   output logic [DATA_WIDTH-1:0]  o_mem_write_data,
   output logic [BURST_WIDTH-1:0] o_mem_burst_count,
   output logic                   o_mem_burst_begin,
   output logic                   o_mem_read_req,
   output logic                   o_mem_write_req,
   input  logic                   i_mem_wait_request,
   input  logic [DATA_WIDTH-1:0]  i_mem_read_data,
   input  logic                   i_mem_read_data_valid,
`ifdef BUS_MEM_BRIDGE_STATS_EN
   output logic [31:0]            o_stat_cmd_count,
   output logic [31:0]            o_stat_stall_count,
`endif
   output logic                   o_err_unexpected_rdata
);
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  addr;
      logic [BE_WIDTH-1:0]    be;
      logic                   rd;
      logic                   wr;
      logic [DATA_WIDTH-1:0]  wdata;
      logic [BURST_WIDTH-1:0] bcount;
      logic                   bbegin;
   } cmd_t;

   localparam int CMD_W  = $bits(cmd_t);
   localparam int PEND_W = $clog2(MAX_PENDING_BEATS + 1);
   localparam int SUM_W  = ((PEND_W > BURST_WIDTH) ? PEND_W : BURST_WIDTH) + 1;

   logic [PEND_W-1:0]      pending;
   logic [BURST_WIDTH-1:0] bcount_eff;
   logic [SUM_W-1:0]       need_beats;
   logic [SUM_W-1:0]       pend_inc;
   logic [SUM_W-1:0]       pend_nxt;
   logic                   rd_only;
   logic                   credit_short;
   logic                   bus_accept;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   mem_pop;
   cmd_t                   push_cmd;
   cmd_t                   head_cmd;
   cmd_t                   hold_cmd;
   cmd_t                   mem_cmd;
   logic [CMD_W-1:0]       head_raw;

   // A simultaneous read+write is carried as a write only.
   assign rd_only      = i_bus_read_req && !i_bus_write_req;
   assign bcount_eff   = (i_bus_burst_count == '0) ? BURST_WIDTH'(1) : i_bus_burst_count;
   assign need_beats   = SUM_W'(pending) + SUM_W'(bcount_eff);
   assign credit_short = rd_only && (need_beats > SUM_W'(MAX_PENDING_BEATS));

   assign o_bus_wait_request = fifo_full || credit_short;
   assign bus_accept         = (i_bus_read_req || i_bus_write_req) && !o_bus_wait_request;

   always_comb begin
      push_cmd        = '0;
      push_cmd.addr   = i_bus_address;
      push_cmd.be     = i_bus_be;
      push_cmd.rd     = rd_only;
      push_cmd.wr     = i_bus_write_req;
      push_cmd.wdata  = i_bus_write_data;
      push_cmd.bcount = i_bus_burst_count;
      push_cmd.bbegin = i_bus_burst_begin;
   end

   bus_mem_fifo #(
      .WIDTH      (CMD_W),
      .DEPTH_LOG2 (CMD_DEPTH_LOG2)
   ) u_cmd_fifo (
      .clk      (i_clock),
      .rst      (i_reset),
      .push     (bus_accept),
      .push_dat (push_cmd),
      .pop      (mem_pop),
      .head_dat (head_raw),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign head_cmd = cmd_t'(head_raw);
   // When the FIFO drains the memory fields keep showing the last issued command.
   assign mem_cmd  = fifo_empty ? hold_cmd : head_cmd;

   assign o_mem_address     = mem_cmd.addr;
   assign o_mem_be          = mem_cmd.be;
   assign o_mem_write_data  = mem_cmd.wdata;
   assign o_mem_burst_count = mem_cmd.bcount;
   assign o_mem_burst_begin = mem_cmd.bbegin;
   assign o_mem_read_req    = !fifo_empty && head_cmd.rd;
   assign o_mem_write_req   = !fifo_empty && head_cmd.wr;
   assign mem_pop           = (o_mem_read_req || o_mem_write_req) && !i_mem_wait_request;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         hold_cmd <= '0;
      else if (mem_pop)
         hold_cmd <= head_cmd;
   end

   // Credits: whole burst reserved at accept, released one beat per bus return.
   always_comb begin
      pend_inc = (bus_accept && rd_only) ? SUM_W'(bcount_eff) : '0;
      pend_nxt = SUM_W'(pending) + pend_inc;
      if (o_bus_read_data_valid && (pending != '0))
         pend_nxt = pend_nxt - SUM_W'(1);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         pending                <= '0;
         o_bus_read_data        <= '0;
         o_bus_read_data_valid  <= 1'b0;
         o_err_unexpected_rdata <= 1'b0;
      end else begin
         pending               <= pend_nxt[PEND_W-1:0];
         o_bus_read_data       <= i_mem_read_data;
         o_bus_read_data_valid <= i_mem_read_data_valid;
         if (o_bus_read_data_valid && (pending == '0))
            o_err_unexpected_rdata <= 1'b1;
      end
   end

`ifdef BUS_MEM_BRIDGE_STATS_EN
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_stat_cmd_count   <= '0;
         o_stat_stall_count <= '0;
      end else begin
         if (mem_pop && (o_stat_cmd_count != 32'hFFFF_FFFF))
            o_stat_cmd_count <= o_stat_cmd_count + 32'd1;
         if ((i_bus_read_req || i_bus_write_req) && o_bus_wait_request &&
             (o_stat_stall_count != 32'hFFFF_FFFF))
            o_stat_stall_count <= o_stat_stall_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_bus_mem_pipeline_bridge.sv
// Bench for bus_mem_pipeline_bridge: table vectors, directed corner sequences and random traffic vs a queue model.
module tb_bus_mem_pipeline_bridge;
   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] i_bus_address = '0;
   logic [7:0]  i_bus_be = '0;
   logic        i_bus_read_req = 1'b0;
   logic        i_bus_write_req = 1'b0;
   logic [63:0] i_bus_write_data = '0;
   logic [7:0]  i_bus_burst_count = '0;
   logic        i_bus_burst_begin = 1'b0;
   logic        o_bus_wait_request;
   logic [63:0] o_bus_read_data;
   logic        o_bus_read_data_valid;
   logic [31:0] o_mem_address;
   logic [7:0]  o_mem_be;
   logic [63:0] o_mem_write_data;
   logic [7:0]  o_mem_burst_count;
   logic        o_mem_burst_begin;
   logic        o_mem_read_req;
   logic        o_mem_write_req;
   logic        i_mem_wait_request = 1'b0;
   logic [63:0] i_mem_read_data = '0;
   logic        i_mem_read_data_valid = 1'b0;
   logic        o_err_unexpected_rdata;
`ifdef BUS_MEM_BRIDGE_STATS_EN
   logic [31:0] o_stat_cmd_count;
   logic [31:0] o_stat_stall_count;
`endif

   bus_mem_pipeline_bridge dut (
      .i_clock               (i_clock),
      .i_reset               (i_reset),
      .i_bus_address         (i_bus_address),
      .i_bus_be              (i_bus_be),
      .i_bus_read_req        (i_bus_read_req),
      .i_bus_write_req       (i_bus_write_req),
      .i_bus_write_data      (i_bus_write_data),
      .i_bus_burst_count     (i_bus_burst_count),
      .i_bus_burst_begin     (i_bus_burst_begin),
      .o_bus_wait_request    (o_bus_wait_request),
      .o_bus_read_data       (o_bus_read_data),
      .o_bus_read_data_valid (o_bus_read_data_valid),
      .o_mem_address         (o_mem_address),
      .o_mem_be              (o_mem_be),
      .o_mem_write_data      (o_mem_write_data),
      .o_mem_burst_count     (o_mem_burst_count),
      .o_mem_burst_begin     (o_mem_burst_begin),
      .o_mem_read_req        (o_mem_read_req),
      .o_mem_write_req       (o_mem_write_req),
      .i_mem_wait_request    (i_mem_wait_request),
      .i_mem_read_data       (i_mem_read_data),
      .i_mem_read_data_valid (i_mem_read_data_valid),
`ifdef BUS_MEM_BRIDGE_STATS_EN
      .o_stat_cmd_count      (o_stat_cmd_count),
      .o_stat_stall_count    (o_stat_stall_count),
`endif
      .o_err_unexpected_rdata(o_err_unexpected_rdata)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      logic        rd, wr, bb, mwait, mrv;
      logic [7:0]  bc, be;
      logic [31:0] addr;
      logic [63:0] wdata, mrd;
   } stim_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  be;
      logic        rd, wr;
      logic [63:0] wdata;
      logic [7:0]  bc;
      logic        bb;
   } mcmd_t;

   typedef struct {
      logic        rd, wr;
      logic [7:0]  bc;
      logic [31:0] addr;
      logic        exp_wait, exp_mrd, exp_mwr;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int proto_viol = 0;

   // Reference model: command queue, outstanding-beat budget, registered return slot.
   mcmd_t       mq[$];
   mcmd_t       hold;
   int          pending, owed, stat_cmd, stat_stall;
   bit          err, ov;
   logic [63:0] od;

   logic        last_wait, last_mrd, last_mwr, last_rvalid, last_err;
   logic [31:0] last_maddr;
   logic [63:0] last_rdata;
   logic [31:0] pop_log[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: cycle budget expired", nm);
   endtask

   function automatic stim_t mk(input bit rd, input bit wr, input logic [7:0] bc,
                                input logic [31:0] addr, input bit mwait);
      stim_t s;
      s.rd = rd; s.wr = wr; s.bc = bc; s.addr = addr; s.mwait = mwait;
      s.be = addr[7:0] ^ 8'h5A; s.bb = addr[4];
      s.wdata = {addr, ~addr}; s.mrv = 1'b0; s.mrd = '0;
      return s;
   endfunction

   function automatic stim_t ret(input logic [63:0] d);
      stim_t s;
      s = mk(0, 0, 8'd0, 32'd0, 0);
      s.mrv = 1'b1; s.mrd = d;
      return s;
   endfunction

   task automatic model_reset();
      mq.delete();
      hold = '0; pending = 0; owed = 0; err = 0; ov = 0; od = '0;
      stat_cmd = 0; stat_stall = 0;
   endtask

   task automatic do_cycle(input stim_t s);
      mcmd_t head, nc;
      bit    empty, rdo, ewait, acc, erd, ewr, pop;
      int    beff;
      i_bus_read_req = s.rd;   i_bus_write_req = s.wr;   i_bus_address = s.addr;
      i_bus_be = s.be;         i_bus_write_data = s.wdata;
      i_bus_burst_count = s.bc; i_bus_burst_begin = s.bb;
      i_mem_wait_request = s.mwait; i_mem_read_data_valid = s.mrv; i_mem_read_data = s.mrd;
      #1;
      empty = (mq.size() == 0);
      head  = empty ? hold : mq[0];
      rdo   = s.rd && !s.wr;
      beff  = (s.bc == 0) ? 1 : int'(s.bc);
      ewait = (mq.size() == 4) || (rdo && (pending + beff > 16));
      acc   = (s.rd || s.wr) && !ewait;
      erd   = !empty && head.rd;
      ewr   = !empty && head.wr;
      pop   = (erd || ewr) && !s.mwait;
      chk("bus_wait", 64'(o_bus_wait_request), 64'(ewait));
      chk("mem_rd_req", 64'(o_mem_read_req), 64'(erd));
      chk("mem_wr_req", 64'(o_mem_write_req), 64'(ewr));
      chk("mem_addr", 64'(o_mem_address), 64'(head.addr));
      chk("mem_be", 64'(o_mem_be), 64'(head.be));
      chk("mem_wdata", o_mem_write_data, head.wdata);
      chk("mem_bcount", 64'(o_mem_burst_count), 64'(head.bc));
      chk("mem_bbegin", 64'(o_mem_burst_begin), 64'(head.bb));
      chk("bus_rvalid", 64'(o_bus_read_data_valid), 64'(ov));
      if (ov) chk("bus_rdata", o_bus_read_data, od);
      chk("err_flag", 64'(o_err_unexpected_rdata), 64'(err));
`ifdef BUS_MEM_BRIDGE_STATS_EN
      chk("stat_cmd", 64'(o_stat_cmd_count), 64'(stat_cmd));
      chk("stat_stall", 64'(o_stat_stall_count), 64'(stat_stall));
`endif
      last_wait = o_bus_wait_request; last_mrd = o_mem_read_req; last_mwr = o_mem_write_req;
      last_maddr = o_mem_address; last_rvalid = o_bus_read_data_valid;
      last_rdata = o_bus_read_data; last_err = o_err_unexpected_rdata;
      if ((o_mem_read_req || o_mem_write_req) && !s.mwait) pop_log.push_back(o_mem_address);
      if (s.rd && s.wr) proto_viol++;
      if (pop) begin hold = mq.pop_front(); stat_cmd++; end
      if (acc) begin
         nc.addr = s.addr; nc.be = s.be; nc.rd = rdo; nc.wr = s.wr;
         nc.wdata = s.wdata; nc.bc = s.bc; nc.bb = s.bb;
         mq.push_back(nc);
         if (rdo) begin pending += beff; owed += beff; end
      end
      if ((s.rd || s.wr) && ewait) stat_stall++;
      if (ov) begin
         if (pending > 0) pending--;
         else err = 1;
      end
      if (s.mrv && owed > 0) owed--;
      ov = s.mrv; od = s.mrd;
      @(posedge i_clock); #1;
   endtask

   task automatic issue(input stim_t s, input string nm);
      for (int n = 0; n < 50; n++) begin
         do_cycle(s);
         if (!last_wait) return;
      end
      timeout(nm);
   endtask

   task automatic drain(input string nm);
      stim_t s;
      for (int n = 0; n < 400; n++) begin
         if (owed == 0 && mq.size() == 0 && !ov) return;
         s = mk(0, 0, 8'd0, 32'd0, 0);
         s.mrv = (owed > 0); s.mrd = {$urandom, $urandom};
         do_cycle(s);
      end
      timeout(nm);
   endtask

   task automatic hit_reset();
      i_bus_read_req = 0; i_bus_write_req = 0; i_mem_wait_request = 0; i_mem_read_data_valid = 0;
      i_reset = 1'b1;
      #1;
      chk("rst_mem_rd_req", 64'(o_mem_read_req), 64'd0);
      chk("rst_mem_wr_req", 64'(o_mem_write_req), 64'd0);
      chk("rst_bus_wait", 64'(o_bus_wait_request), 64'd0);
      chk("rst_rvalid", 64'(o_bus_read_data_valid), 64'd0);
      chk("rst_err", 64'(o_err_unexpected_rdata), 64'd0);
      @(posedge i_clock); #1;
      i_reset = 1'b0;
      model_reset();
   endtask

   initial begin
      vec_t        vt[8];
      stim_t       s;
      logic [31:0] t2_addr[5];
      int          strobes, acc_k;
      bit          acc2;

      vt[0] = '{rd:0, wr:1, bc:8'd1,  addr:32'h100, exp_wait:0, exp_mrd:0, exp_mwr:1};
      vt[1] = '{rd:1, wr:0, bc:8'd4,  addr:32'h200, exp_wait:0, exp_mrd:1, exp_mwr:0};
      vt[2] = '{rd:1, wr:0, bc:8'd0,  addr:32'h300, exp_wait:0, exp_mrd:1, exp_mwr:0};
      vt[3] = '{rd:1, wr:1, bc:8'd2,  addr:32'h400, exp_wait:0, exp_mrd:0, exp_mwr:1};
      vt[4] = '{rd:1, wr:0, bc:8'd12, addr:32'h500, exp_wait:1, exp_mrd:0, exp_mwr:0};
      vt[5] = '{rd:1, wr:0, bc:8'd11, addr:32'h600, exp_wait:0, exp_mrd:1, exp_mwr:0};
      vt[6] = '{rd:0, wr:1, bc:8'd1,  addr:32'h700, exp_wait:0, exp_mrd:0, exp_mwr:1};
      vt[7] = '{rd:1, wr:0, bc:8'd1,  addr:32'h800, exp_wait:1, exp_mrd:0, exp_mwr:0};

      model_reset();
      #2;
      chk("init_mem_rd_req", 64'(o_mem_read_req), 64'd0);
      chk("init_mem_wr_req", 64'(o_mem_write_req), 64'd0);
      chk("init_bus_wait", 64'(o_bus_wait_request), 64'd0);
      chk("init_mem_addr", 64'(o_mem_address), 64'd0);
      chk("init_err", 64'(o_err_unexpected_rdata), 64'd0);
      @(posedge i_clock); #1;
      i_reset = 1'b0;

      // Vector table: one command, then an idle cycle showing the memory side.
      for (int v = 0; v < 8; v++) begin
         s = mk(vt[v].rd, vt[v].wr, vt[v].bc, vt[v].addr, 0);
         if (v == 0) s.wdata = 64'hDEAD_BEEF;
         do_cycle(s);
         chk($sformatf("tbl%0d_wait", v), 64'(last_wait), 64'(vt[v].exp_wait));
         do_cycle(mk(0, 0, 8'd0, 32'd0, 0));
         chk($sformatf("tbl%0d_mrd", v), 64'(last_mrd), 64'(vt[v].exp_mrd));
         chk($sformatf("tbl%0d_mwr", v), 64'(last_mwr), 64'(vt[v].exp_mwr));
         if (vt[v].exp_mrd || vt[v].exp_mwr)
            chk($sformatf("tbl%0d_maddr", v), 64'(last_maddr), 64'(vt[v].addr));
      end
      drain("tbl_drain");

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         s = mk(r < 3, (r >= 3 && r < 6), 8'($urandom_range(0, 6)), $urandom, ($urandom_range(0, 9) < 3));
         s.wdata = {$urandom, $urandom};
         s.mrv = (owed > 0) && ($urandom_range(0, 1) == 1);
         s.mrd = {$urandom, $urandom};
         do_cycle(s);
      end
      drain("rand_drain");

      // FIFO fill under memory stall, then in-order release.
      for (int i = 0; i < 5; i++) t2_addr[i] = 32'h1000 + 32'(i * 16);
      pop_log.delete();
      for (int i = 0; i < 4; i++) begin
         do_cycle(mk(0, 1, 8'd1, t2_addr[i], 1));
         chk($sformatf("t2_accept%0d", i), 64'(last_wait), 64'd0);
      end
      do_cycle(mk(0, 1, 8'd1, t2_addr[4], 1));
      chk("t2_full_wait", 64'(last_wait), 64'd1);
      issue(mk(0, 1, 8'd1, t2_addr[4], 0), "t2_fifth");
      drain("t2_drain");
      chk("t2_pop_count", 64'(pop_log.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         if (i < pop_log.size()) chk($sformatf("t2_order%0d", i), 64'(pop_log[i]), 64'(t2_addr[i]));

      // Credit limit: 16-beat read then a 1-beat read that waits for the first return.
      strobes = 0; acc2 = 0; acc_k = -1;
      for (int k = 0; k < 26; k++) begin
         s = mk((k == 0) || !acc2, 0, (k == 0) ? 8'd16 : 8'd1, 32'h2000 + 32'(k), 0);
         if (acc2 && k > 0) s.rd = 1'b0;
         s.mrv = (k >= 2 && k < 19);
         s.mrd = 64'hA5A5_0000_0000_0000 + 64'(k);
         do_cycle(s);
         if (k == 0) chk("t3_first_accept", 64'(last_wait), 64'd0);
         else if (!acc2 && !last_wait) begin acc2 = 1; acc_k = k; end
         if (last_rvalid) strobes++;
      end
      chk("t3_second_accept_cycle", 64'(acc_k), 64'd4);
      chk("t3_strobes", 64'(strobes), 64'd17);
      drain("t3_drain");

      // Unexpected beat with nothing outstanding.
      do_cycle(ret(64'h0123_4567_89AB_CDEF));
      do_cycle(mk(0, 0, 8'd0, 32'd0, 0));
      chk("t4_fwd_valid", 64'(last_rvalid), 64'd1);
      chk("t4_fwd_data", last_rdata, 64'h0123_4567_89AB_CDEF);
      do_cycle(mk(0, 0, 8'd0, 32'd0, 0));
      chk("t4_err_set", 64'(last_err), 64'd1);
      for (int i = 0; i < 5; i++) do_cycle(mk(0, 0, 8'd0, 32'd0, 0));
      chk("t4_err_sticky", 64'(last_err), 64'd1);

      // Reset with 3 queued commands and 8 beats outstanding.
      do_cycle(mk(1, 0, 8'd8, 32'h3000, 1));
      do_cycle(mk(0, 1, 8'd1, 32'h3010, 1));
      do_cycle(mk(0, 1, 8'd1, 32'h3020, 1));
      chk("t5_queued", 64'(mq.size()), 64'd3);
      hit_reset();
      do_cycle(ret(64'h5555_AAAA_5555_AAAA));
      do_cycle(mk(0, 0, 8'd0, 32'd0, 0));
      do_cycle(mk(0, 0, 8'd0, 32'd0, 0));
      chk("t5_inflight_err", 64'(last_err), 64'd1);
      hit_reset();
      do_cycle(mk(1, 0, 8'd16, 32'h3100, 0));
      chk("t5_pending_cleared", 64'(last_wait), 64'd0);
      drain("t5_drain");

`ifdef BUS_MEM_BRIDGE_STATS_EN
      hit_reset();
      for (int i = 0; i < 4; i++) do_cycle(mk(0, 1, 8'd1, 32'h4000 + 32'(i), 1));
      for (int i = 0; i < 7; i++) do_cycle(mk(0, 1, 8'd1, 32'h4004, 1));
      do_cycle(mk(0, 0, 8'd0, 32'd0, 0));
      for (int i = 4; i < 10; i++) issue(mk(0, 1, 8'd1, 32'h4000 + 32'(i), 0), "t6_issue");
      drain("t6_drain");
      do_cycle(mk(0, 0, 8'd0, 32'd0, 0));
      chk("t6_cmd_count", 64'(o_stat_cmd_count), 64'd10);
      chk("t6_stall_count", 64'(o_stat_stall_count), 64'd7);
`endif

      if (proto_viol > 0)
         $display("note: %0d cycles drove read and write together (carried as writes)", proto_viol);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
